// File: rtl/exec_pkg.sv
// Shared widths, ALU opcodes and sequencer state encoding for exec_arbiter.
package exec_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 3;
    localparam int RD_W   = 3;
    localparam int IMM_W  = 3;

    // Bit 2 of the opcode selects the immediate form.
    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
    localparam logic [OP_W-1:0] OP_SUBI = 3'b101;
    localparam logic [OP_W-1:0] OP_ANDI = 3'b110;
    localparam logic [OP_W-1:0] OP_ORI  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot mask selecting requester idx.
    function automatic logic [1:0] req_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/exec_arbiter_if.sv
// Requester-side request/response bus of exec_arbiter, both requesters packed.
interface exec_arbiter_if;
    import exec_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_op;
    logic [2*DATA_W-1:0] req_r1;
    logic [2*DATA_W-1:0] req_r2;
    logic [2*IMM_W-1:0]  req_imm;
    logic [2*RD_W-1:0]   req_rd;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic [RD_W-1:0]     resp_rd;

    // Requesters side.
    modport master (
        output req_valid, req_op, req_r1, req_r2, req_imm, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_r1, req_r2, req_imm, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a tie
// and moves to the other requester after every grant.
module rr_arb2
    import exec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_ptr;

    // Combinational grant: a lone request wins, a tie goes to rr_ptr.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = req_mask(rr_ptr);
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer moves to the requester that did not just win.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (gnt[0]) begin
            rr_ptr <= 1'b1;
        end else if (gnt[1]) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared 16-bit execute unit.
// One operation in flight: grant (IDLE or RESP handshake) -> EXEC -> RESP.
// Optional macro EXEC_ARB_STATS_EN adds per-requester 16-bit grant counters.
module exec_arbiter
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    exec_arbiter_if.slave     bus,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [IMM_W-1:0]  alu_imm,
    output logic [OP_W-1:0]   alu_op,
    output logic [RD_W-1:0]   alu_rd,
    output logic              alu_flush,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [RD_W-1:0]   alu_rd_out
`ifdef EXEC_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    state_t            state;
    logic              owner;
    logic [1:0]        gnt;
    logic              resp_hs;
    logic              grant_en;
    logic [1:0]        resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [RD_W-1:0]   resp_rd_q;

    // In RESP the owner's resp_valid is always set, so its ready completes the handshake.
    assign resp_hs  = (state == RESP) && bus.resp_ready[owner];
    assign grant_en = (state == IDLE) || resp_hs;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req_valid),
        .en    (grant_en),
        .gnt   (gnt)
    );

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;

    // Execute unit is held in reset whenever nothing is being sequenced.
    assign alu_flush = (state == IDLE) || !reset;

    // Sequencer: latch winner's payload on grant, capture result in EXEC, hold it in RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            alu_r1       <= '0;
            alu_r2       <= '0;
            alu_imm      <= '0;
            alu_op       <= '0;
            alu_rd       <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
        end else begin
            if (|gnt) begin
                owner   <= gnt[1];
                alu_op  <= gnt[1] ? bus.req_op[OP_W +: OP_W]       : bus.req_op[0 +: OP_W];
                alu_r1  <= gnt[1] ? bus.req_r1[DATA_W +: DATA_W]   : bus.req_r1[0 +: DATA_W];
                alu_r2  <= gnt[1] ? bus.req_r2[DATA_W +: DATA_W]   : bus.req_r2[0 +: DATA_W];
                alu_imm <= gnt[1] ? bus.req_imm[IMM_W +: IMM_W]    : bus.req_imm[0 +: IMM_W];
                alu_rd  <= gnt[1] ? bus.req_rd[RD_W +: RD_W]       : bus.req_rd[0 +: RD_W];
            end
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q  <= alu_data;
                    resp_rd_q    <= alu_rd_out;
                    resp_valid_q <= req_mask(owner);
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_hs) begin
                        resp_valid_q <= 2'b00;
                        state        <= (|gnt) ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef EXEC_ARB_STATS_EN
    // Grant counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt[0]) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (gnt[1]) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_arbiter.sv
// Self-checking bench for exec_arbiter: queued stimulus per requester, a simple
// behavioural execute unit, and a cycle monitor checking against the arbitration rules.
module tb_exec_arbiter;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    exec_arbiter_if bus();

    logic [DATA_W-1:0] alu_r1, alu_r2, alu_data;
    logic [IMM_W-1:0]  alu_imm;
    logic [OP_W-1:0]   alu_op;
    logic [RD_W-1:0]   alu_rd, alu_rd_out;
    logic              alu_flush;
`ifdef EXEC_ARB_STATS_EN
    logic [15:0]       grant_cnt0, grant_cnt1;
`endif

    exec_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_r1     (alu_r1),
        .alu_r2     (alu_r2),
        .alu_imm    (alu_imm),
        .alu_op     (alu_op),
        .alu_rd     (alu_rd),
        .alu_flush  (alu_flush),
        .alu_data   (alu_data),
        .alu_rd_out (alu_rd_out)
`ifdef EXEC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    // Behavioural execute unit; immediate forms combine r2 with zero-extended imm.
    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] r1,
                                                input logic [DATA_W-1:0] r2, input logic [IMM_W-1:0] imm);
        logic [DATA_W-1:0] a, b;
        a = op[2] ? r2 : r1;
        b = op[2] ? {{(DATA_W-IMM_W){1'b0}}, imm} : r2;
        case (op)
            OP_ADD, OP_ADDI: return a + b;
            OP_SUB, OP_SUBI: return a - b;
            OP_AND, OP_ANDI: return a & b;
            default:         return a | b;
        endcase
    endfunction

    assign alu_data   = alu_f(alu_op, alu_r1, alu_r2, alu_imm);
    assign alu_rd_out = alu_rd;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [IMM_W-1:0]  imm;
        logic [RD_W-1:0]   rd;
        int                gap;
    } txn_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } resp_t;

    txn_t  stimq [2][$];
    resp_t expq  [2][$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Requester driver state
    logic [1:0] v;
    logic [1:0] rr;
    txn_t       cur [2];
    int         gapc [2];
    bit         active [2];
    bit         pending [2];
    int         stall_n [2];
    int         wait_c [2];
    bit         rand_mode;

    assign bus.req_valid  = v;
    assign bus.resp_ready = rr;
    assign bus.req_op     = {cur[1].op,  cur[0].op};
    assign bus.req_r1     = {cur[1].r1,  cur[0].r1};
    assign bus.req_r2     = {cur[1].r2,  cur[0].r2};
    assign bus.req_imm    = {cur[1].imm, cur[0].imm};
    assign bus.req_rd     = {cur[1].rd,  cur[0].rd};

    // Driver: accepted requests push their expected response, new requests start after their gap.
    initial begin
        logic [1:0] hs;
        bit rst_seen;
        v = 2'b00;
        rr = 2'b00;
        rand_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur[i] = '{op: '0, r1: '0, r2: '0, imm: '0, rd: '0, gap: 0};
            gapc[i] = 0; active[i] = 0; pending[i] = 0; stall_n[i] = 0; wait_c[i] = 0;
        end
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            rst_seen = !reset;
            @(posedge clk);
            #1;
            if (rst_seen) begin
                v = 2'b00;
                rr = 2'b00;
                for (int i = 0; i < 2; i++) begin
                    active[i] = 0; pending[i] = 0; wait_c[i] = 0;
                    expq[i].delete();
                    stimq[i].delete();
                end
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    expq[i].push_back('{data: alu_f(cur[i].op, cur[i].r1, cur[i].r2, cur[i].imm), rd: cur[i].rd});
                    active[i] = 0;
                    v[i] = 1'b0;
                end else if (v[i] && rand_mode && $urandom_range(0, 15) == 0) begin
                    active[i] = 0;
                    v[i] = 1'b0;
                end
                if (!active[i] && !pending[i] && stimq[i].size() > 0) begin
                    cur[i] = stimq[i].pop_front();
                    gapc[i] = cur[i].gap;
                    pending[i] = 1;
                end
                if (pending[i]) begin
                    if (gapc[i] == 0) begin
                        v[i] = 1'b1;
                        active[i] = 1;
                        pending[i] = 0;
                    end else begin
                        gapc[i]--;
                    end
                end
                if (bus.resp_valid[i]) begin
                    rr[i] = (wait_c[i] >= stall_n[i]) && (!rand_mode || $urandom_range(0, 2) != 0);
                    wait_c[i]++;
                end else begin
                    wait_c[i] = 0;
                    rr[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    end

    // Monitor: one operation in flight, response exactly two cycles after grant.
    initial begin
        int          cyc;
        int          gcyc;
        bit          busy;
        bit          owner_m;
        bit          mptr;
        bit          hs_resp;
        bit          allowed;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        txn_t        lat;
        resp_t       r;
        logic [DATA_W-1:0] hold_data;
        logic [RD_W-1:0]   hold_rd;
        logic [15:0] gcnt [2];
        int          w;
        cyc = 0; gcyc = 0; busy = 0; owner_m = 0; mptr = 0;
        hold_data = '0; hold_rd = '0;
        gcnt[0] = '0; gcnt[1] = '0;
        lat = '{op: '0, r1: '0, r2: '0, imm: '0, rd: '0, gap: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                busy = 0; mptr = 0; gcnt[0] = '0; gcnt[1] = '0;
                continue;
            end
            check("alu_flush", {31'd0, alu_flush}, {31'd0, !busy});
            exp_rv = (busy && cyc >= gcyc + 2) ? req_mask(owner_m) : 2'b00;
            check("resp_valid", {30'd0, bus.resp_valid}, {30'd0, exp_rv});
            if (busy && cyc == gcyc + 1) begin
                check("exec_alu_op",  {29'd0, alu_op},  {29'd0, lat.op});
                check("exec_alu_r1",  {16'd0, alu_r1},  {16'd0, lat.r1});
                check("exec_alu_r2",  {16'd0, alu_r2},  {16'd0, lat.r2});
                check("exec_alu_imm", {29'd0, alu_imm}, {29'd0, lat.imm});
                check("exec_alu_rd",  {29'd0, alu_rd},  {29'd0, lat.rd});
            end
            if (busy && cyc == gcyc + 2) begin
                hold_data = bus.resp_data;
                hold_rd = bus.resp_rd;
            end else if (busy && cyc > gcyc + 2) begin
                check("resp_data_stable", {16'd0, bus.resp_data}, {16'd0, hold_data});
                check("resp_rd_stable",   {29'd0, bus.resp_rd},   {29'd0, hold_rd});
            end
            hs_resp = busy && (cyc >= gcyc + 2) && bus.resp_ready[owner_m];
            allowed = !busy || hs_resp;
            if (hs_resp) begin
                if (expq[owner_m].size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = expq[owner_m].pop_front();
                    check("resp_data", {16'd0, bus.resp_data}, {16'd0, r.data});
                    check("resp_rd",   {29'd0, bus.resp_rd},   {29'd0, r.rd});
                end
                busy = 0;
            end
`ifdef EXEC_ARB_STATS_EN
            check("grant_cnt0", {16'd0, grant_cnt0}, {16'd0, gcnt[0]});
            check("grant_cnt1", {16'd0, grant_cnt1}, {16'd0, gcnt[1]});
`endif
            exp_rdy = 2'b00;
            if (allowed) begin
                exp_rdy = (bus.req_valid == 2'b11) ? req_mask(mptr) : bus.req_valid;
            end
            check("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
            if (exp_rdy != 2'b00) begin
                owner_m = exp_rdy[1];
                w = owner_m ? 1 : 0;
                lat.op  = bus.req_op[w*OP_W +: OP_W];
                lat.r1  = bus.req_r1[w*DATA_W +: DATA_W];
                lat.r2  = bus.req_r2[w*DATA_W +: DATA_W];
                lat.imm = bus.req_imm[w*IMM_W +: IMM_W];
                lat.rd  = bus.req_rd[w*RD_W +: RD_W];
                busy = 1;
                gcyc = cyc;
                mptr = !owner_m;
                gcnt[w] = gcnt[w] + 16'd1;
            end
        end
    end

    task automatic push(input int i, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] r1,
                        input logic [DATA_W-1:0] r2, input logic [IMM_W-1:0] imm,
                        input logic [RD_W-1:0] rd, input int gap);
        stimq[i].push_back('{op: op, r1: r1, r2: r2, imm: imm, rd: rd, gap: gap});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((stimq[0].size() + stimq[1].size() + expq[0].size() + expq[1].size()) != 0 ||
               v != 2'b00 || pending[0] || pending[1] || bus.resp_valid != 2'b00) begin
            if (n >= 3000) break;
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, 32'd1, 32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Plain ADD from requester 0
        push(0, OP_ADD, 16'h0005, 16'h0003, 3'd0, 3'd2, 0);
        wait_idle("add");

        // Tie after reset: requester 0 first, then 1
        pulse_reset();
        push(0, OP_SUB, 16'h000A, 16'h0004, 3'd0, 3'd1, 0);
        push(1, OP_OR,  16'h00F0, 16'h000F, 3'd0, 3'd5, 0);
        push(0, OP_AND, 16'h0F0F, 16'h00FF, 3'd0, 3'd3, 0);
        wait_idle("tie");

        // Requester 1 response stalled 4 cycles while requester 0 waits
        stall_n[1] = 4;
        push(1, OP_AND, 16'h1234, 16'hFF00, 3'd0, 3'd6, 0);
        push(0, OP_ORI, 16'h0000, 16'h0100, 3'd5, 3'd7, 1);
        wait_idle("stall");
        stall_n[1] = 0;

        // Immediate add wrapping modulo 2^16
        push(0, OP_ADDI, 16'hFFFF, 16'hFFFF, 3'd7, 3'd4, 0);
        wait_idle("addi_wrap");

        // Reset while the response is held
        stall_n[0] = 10;
        push(0, OP_SUBI, 16'h0000, 16'h0010, 3'd3, 3'd1, 0);
        n = 0;
        while (bus.resp_valid[0] !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) check("resp_before_reset_timeout", 32'd1, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        check("rst_alu_flush", {31'd0, alu_flush}, 32'd1);
`ifdef EXEC_ARB_STATS_EN
        check("rst_grant_cnt0", {16'd0, grant_cnt0}, 32'd0);
        check("rst_grant_cnt1", {16'd0, grant_cnt1}, 32'd0);
`endif
        stall_n[0] = 0;
        repeat (2) @(posedge clk);
        #2;

        // Requester 1 raises valid in the cycle requester 0's response completes
        push(0, OP_ADD, 16'h0100, 16'h0023, 3'd0, 3'd2, 0);
        push(1, OP_SUB, 16'h0050, 16'h0051, 3'd0, 3'd3, 2);
        wait_idle("back_to_back");

        // Randomized traffic with backpressure and withdrawn requests
        rand_mode = 1'b1;
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 2; i++) begin
                push(i, OP_W'($urandom_range(0, 7)), DATA_W'($urandom), DATA_W'($urandom),
                     IMM_W'($urandom_range(0, 7)), RD_W'($urandom_range(0, 7)), $urandom_range(0, 3));
            end
        end
        wait_idle("random");
        rand_mode = 1'b0;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_arbiter.md
Name: exec_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 16-bit execute unit (ALU). Accepts ALU operations from two sources (main pipeline, auxiliary/DMA path) over valid/ready handshakes. Drives the execute unit's operand, op, rd and flush inputs from registers and captures its combinational result. Returns the result and destination register to the granted requester.

Parameters:
DATA_W, 16, operand/result width
OP_W, 3, aluop width (bit 2 = immediate form)
RD_W, 3, destination register address width
IMM_W, 3, immediate width, zero-extended by the execute unit

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-low
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept, one-hot or zero
req_op  in  2*OP_W  aluop, requester i at [OP_W*i +: OP_W]
req_r1  in  2*DATA_W  r1 operand, same packing
req_r2  in  2*DATA_W  r2 operand
req_imm  in  2*IMM_W  immediate
req_rd  in  2*RD_W  destination register
resp_valid  out  2  per-requester result valid
resp_ready  in  2  per-requester result accept
resp_data  out  DATA_W  result, shared bus, valid only with a resp_valid bit
resp_rd  out  RD_W  destination register of result
alu_r1, alu_r2  out  DATA_W  to execute unit
alu_imm  out  IMM_W  to execute unit
alu_op  out  OP_W  to execute unit
alu_rd  out  RD_W  to execute unit
alu_flush  out  1  drives execute unit's active-high reset input
alu_data  in  DATA_W  from execute unit (combinational)
alu_rd_out  in  RD_W  from execute unit

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (reset==0 at clk edge): state=IDLE, rr_ptr=0, all alu_* and resp_* regs=0, resp_valid=0.
- alu_flush=1 in IDLE and whenever reset==0; 0 in EXEC and RESP.
- Grant, combinational: both valid -> grant rr_ptr. One valid -> grant it. On any grant to i, rr_ptr<=~i.
- req_ready[i]=1 only in the grant cycle: in IDLE, or in RESP when the response handshake completes that same cycle. A requester holds its payload stable while valid && !ready.
- Grant cycle T: latch req_op/r1/r2/imm/rd of winner into alu_* regs and owner reg; next state EXEC.
- EXEC (T+1): alu_* stable. Capture resp_data<=alu_data and resp_rd<=alu_rd_out at end of cycle. Set resp_valid[owner]; next state RESP.
- RESP (from T+2): hold resp_valid[owner], resp_data and resp_rd stable until resp_ready[owner]=1.
  - On handshake with no req_valid: go to IDLE.
  - On handshake with a pending req_valid: grant in the same cycle, go to EXEC (back-to-back, 2-cycle issue interval).
- Request-to-response latency: exactly 2 cycles with no backpressure. At most one operation in flight.
- Arithmetic: none in this block. Widths pass through unchanged. Wrap-around is produced by the execute unit modulo 2^16.
- resp_ready on a non-owner bit is ignored. req_valid deasserted without handshake is legal; the request is simply not granted.
- Reset mid-operation: in-flight op is dropped with no response. Next cycle: resp_valid=0, IDLE, alu_flush=1.

Optional Feature:
EXEC_ARB_STATS_EN
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16-bit each). Each increments on its requester's grant, wraps 0xFFFF->0x0000, and clears on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package exec_pkg holds:
  - DATA_W, OP_W, RD_W, IMM_W
  - aluop constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_ADDI=100, OP_SUBI=101, OP_ANDI=110, OP_ORI=111
  - FSM state encoding
- Sub-module rr_arb2: 2-way round-robin grant logic with rr_ptr update.

Test Plan:
1. req0 ADD r1=0x0005, r2=0x0003, rd=2 at T -> req_ready[0]=1 at T; alu_op=000 at T+1; resp_valid[0]=1 at T+2 with resp_data=0x0008, resp_rd=2.
2. After reset, both valid: req0 SUB 0x000A-0x0004, req1 OR 0x00F0|0x000F -> req0 granted first, resp 0x0006; then req1, resp 0x00FF; rr_ptr alternates 0,1,0.
3. req1 response with resp_ready[1]=0 for 4 cycles, req0 valid throughout -> resp_valid[1] and resp_data stable, req_ready=00 all 4 cycles; req0 granted in the cycle resp_ready[1] rises.
4. req0 ADDI imm=7, r2=0xFFFF -> resp_data=0x0006 (wrap).
5. reset=0 during RESP -> next cycle resp_valid=00, alu_flush=1, state IDLE, stat counters 0 when EXEC_ARB_STATS_EN is defined.
6. Response handshake in the same cycle req1 becomes valid -> req_ready[1]=1 that cycle, resp_valid[1] two cycles later, no IDLE cycle in between.
